// File: rtl/mem_interconnect_pkg.sv
// Shared types and constants for the two-master memory interconnect.
package mem_interconnect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } master_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;
    localparam int CNT_W   = 2;

    localparam logic [31:0] TEXT_BASE = 32'h0000_0000;
    localparam logic [31:0] TEXT_END  = 32'h0000_0FFF;
    localparam logic [31:0] DMEM_BASE = 32'h0000_1000;
    localparam logic [31:0] DMEM_END  = 32'h0000_1FFF;

endpackage

// File: rtl/mem_interconnect_region_decoder.sv
// Combinational address decode: one-hot region hit plus access error flag.
module region_decoder
    import mem_interconnect_pkg::*;
#(
    parameter int                WIDTH = 32,
    parameter int                NREG  = 2,
    parameter logic [WIDTH-1:0]  REG_BASE [NREG] = '{TEXT_BASE, DMEM_BASE},
    parameter logic [WIDTH-1:0]  REG_END  [NREG] = '{TEXT_END, DMEM_END},
    parameter logic [NREG-1:0]   REG_RO = 2'b01
) (
    input  logic [WIDTH-1:0] addr,
    input  logic             we,
    output logic [NREG-1:0]  hit,
    output logic             err
);

    // Descending scan so the lowest-index overlapping region wins.
    always_comb begin
        hit = '0;
        for (int k = NREG - 1; k >= 0; k--) begin
            if (addr >= REG_BASE[k] && addr <= REG_END[k]) begin
                hit    = '0;
                hit[k] = 1'b1;
            end
        end
        err = (hit == '0) || (addr[1:0] != 2'b00) || (we && ((hit & REG_RO) != '0));
    end

endmodule

// File: rtl/mem_interconnect.sv
// Arbitrates instruction and data masters onto region-selected slaves,
// one transaction at a time with a fixed grant-to-response latency.
module mem_interconnect
    import mem_interconnect_pkg::*;
#(
    parameter int                WIDTH = 32,
    parameter int                NREG  = 2,
    parameter logic [WIDTH-1:0]  REG_BASE [NREG] = '{TEXT_BASE, DMEM_BASE},
    parameter logic [WIDTH-1:0]  REG_END  [NREG] = '{TEXT_END, DMEM_END},
    parameter logic [NREG-1:0]   REG_RO = 2'b01,
    parameter int                LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [WIDTH-1:0]      i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [WIDTH-1:0]      i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [WIDTH-1:0]      d_addr,
    input  logic [WIDTH-1:0]      d_wdata,
    input  logic [3:0]            d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [WIDTH-1:0]      d_rdata,
    output logic                  d_err,
    output logic [NREG-1:0]       s_sel,
    output logic                  s_we,
    output logic [WIDTH-3:0]      s_addr,
    output logic [WIDTH-1:0]      s_wdata,
    output logic [3:0]            s_be,
    input  logic [NREG*WIDTH-1:0] s_rdata
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    master_t          last_mst, owner;
    logic             cur_we;
    logic [WIDTH-1:0] cur_addr, cur_wdata;
    logic [3:0]       cur_be;
    logic             grant_i, grant_d;
    logic [NREG-1:0]  hit;
    logic             dec_err;
    logic [WIDTH-1:0] rd_sel, resp_data;

    region_decoder #(
        .WIDTH    (WIDTH),
        .NREG     (NREG),
        .REG_BASE (REG_BASE),
        .REG_END  (REG_END),
        .REG_RO   (REG_RO)
    ) u_dec (
        .addr (cur_addr),
        .we   (cur_we),
        .hit  (hit),
        .err  (dec_err)
    );

    // Gated by rst_n so no grant is visible while reset is held.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == ST_IDLE && rst_n) begin
            if (i_req && d_req) begin
                if (last_mst == MST_I) grant_d = 1'b1;
                else                   grant_i = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NREG; k++) begin
            if (hit[k]) rd_sel = s_rdata[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            last_mst  <= MST_I;
            owner     <= MST_I;
            cur_we    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            cur_be    <= '0;
        end else begin
            state <= state_nxt;
            if (grant_i || grant_d) begin
                last_mst  <= grant_d ? MST_D : MST_I;
                owner     <= grant_d ? MST_D : MST_I;
                cur_we    <= grant_d && d_we;
                cur_addr  <= grant_d ? d_addr : i_addr;
                cur_wdata <= grant_d ? d_wdata : '0;
                cur_be    <= grant_d ? d_be : 4'hF;
            end
            if (state == ST_ACCESS && LAT > 1) begin
                cnt <= CNT_W'(LAT - 2);
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        s_sel     = '0;
        s_we      = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        s_be      = '0;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        i_err     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;
        resp_data = (dec_err || cur_we) ? '0 : rd_sel;
        unique case (state)
            ST_IDLE: begin
                if (grant_i || grant_d) state_nxt = ST_ACCESS;
            end
            ST_ACCESS, ST_WAIT: begin
                s_sel   = dec_err ? '0 : hit;
                s_we    = (state == ST_ACCESS) && cur_we && !dec_err;
                s_addr  = cur_addr[WIDTH-1:2];
                s_wdata = cur_wdata;
                s_be    = cur_be;
                if (state == ST_ACCESS) state_nxt = (LAT > 1) ? ST_WAIT : ST_RESP;
                else if (cnt == '0)     state_nxt = ST_RESP;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
                if (owner == MST_I) begin
                    i_rvalid = 1'b1;
                    i_rdata  = resp_data;
                    i_err    = dec_err;
                end else begin
                    d_rvalid = 1'b1;
                    d_rdata  = resp_data;
                    d_err    = dec_err;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;

endmodule
